instr_aligner: RTL and testbench

- Sits between the instruction fetch unit and the compressed-instruction decompressor in the RV32IC front end.
- Takes 32-bit word-aligned fetch words and outputs one instruction per handshake, each with its PC.
- Handles back-to-back 16-bit instructions, 32-bit instructions that straddle two fetch words, and redirects to halfword-aligned targets.
- Output is raw: a compressed instruction appears in [15:0], upper half zero. The downstream decompressor expands it.

---
 rtl/instr_aligner.sv | 169 ++++++++++++++++
 tb/tb_instr_aligner.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
// instr_aligner: splits 32-bit fetch words into instructions with PCs.
// Define ALIGNER_COMPRESSED_EN for RV32IC; default build is RV32I-only.
module instr_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_data_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_is_c_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  logic [31:0] pc_q, pc_d;
  logic        kill;
  logic        ivalid, fready;
  logic [31:0] instr;
  logic        ihs;

  // Reset and flush squash every handshake in their cycle.
  assign kill          = rst_i | flush_i;
  assign instr_pc_o    = pc_q;
  assign instr_valid_o = ivalid & ~kill;
  assign fetch_ready_o = fready & ~kill;
  assign instr_o       = kill ? 32'h0 : instr;
  assign ihs           = instr_valid_o & instr_ready_i;

`ifdef ALIGNER_COMPRESSED_EN
  typedef enum logic [1:0] {
    M_PEND_C,
    M_STRADDLE,
    M_SKIP,
    M_DIRECT
  } mode_e;

  mode_e       mode;
  logic        fhs;
  logic [15:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic        skip_q, skip_d;
  logic        pend_w, lo_c;

  assign fhs          = fetch_valid_i & fetch_ready_o;
  assign pend_w       = pend_q[1:0] == 2'b11;
  assign lo_c         = fetch_data_i[1:0] != 2'b11;
  assign instr_is_c_o = ~kill & (instr_o[1:0] != 2'b11);

  always_comb begin
    mode = M_DIRECT;
    unique case (1'b1)
      pend_valid_q & ~pend_w:  mode = M_PEND_C;
      pend_valid_q & pend_w:   mode = M_STRADDLE;
      ~pend_valid_q & skip_q:  mode = M_SKIP;
      ~pend_valid_q & ~skip_q: mode = M_DIRECT;
    endcase
  end

  always_comb begin
    ivalid = 1'b0;
    fready = 1'b0;
    instr  = 32'h0;
    unique case (mode)
      M_PEND_C: begin
        ivalid = 1'b1;
        instr  = {16'h0, pend_q};
      end
      M_STRADDLE: begin
        ivalid = fetch_valid_i;
        fready = instr_ready_i;
        instr  = {fetch_data_i[15:0], pend_q};
      end
      M_SKIP: begin
        fready = 1'b1;
      end
      M_DIRECT: begin
        ivalid = fetch_valid_i;
        fready = instr_ready_i;
        instr  = lo_c ? {16'h0, fetch_data_i[15:0]}
                      : fetch_data_i;
      end
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    skip_d       = skip_q;
    if (flush_i) begin
      pc_d         = flush_pc_i;
      pend_valid_d = 1'b0;
      skip_d       = flush_pc_i[1];
    end else begin
      unique case (mode)
        M_PEND_C: begin
          if (ihs) begin
            pend_valid_d = 1'b0;
            pc_d         = pc_q + 32'd2;
          end
        end
        M_STRADDLE: begin
          // Buffer drains and refills in the same beat.
          if (ihs) begin
            pend_d = fetch_data_i[31:16];
            pc_d   = pc_q + 32'd4;
          end
        end
        M_SKIP: begin
          if (fhs) begin
            pend_d       = fetch_data_i[31:16];
            pend_valid_d = 1'b1;
            skip_d       = 1'b0;
          end
        end
        M_DIRECT: begin
          if (ihs && lo_c) begin
            pend_d       = fetch_data_i[31:16];
            pend_valid_d = 1'b1;
            pc_d         = pc_q + 32'd2;
          end else if (ihs) begin
            pc_d = pc_q + 32'd4;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q       <= 16'h0;
      pend_valid_q <= 1'b0;
      skip_q       <= RESET_PC[1];
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      skip_q       <= skip_d;
    end
  end
`else
  logic unused_flush_lsb;

  assign unused_flush_lsb = ^flush_pc_i[1:0];
  assign instr_is_c_o     = 1'b0;
  assign ivalid           = fetch_valid_i;
  assign fready           = instr_ready_i;
  assign instr            = fetch_data_i;

  always_comb begin
    pc_d = pc_q;
    if (flush_i) begin
      pc_d = {flush_pc_i[31:2], 2'b00};
    end else if (ihs) begin
      pc_d = pc_q + 32'd4;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_instr_aligner.sv
// tb_instr_aligner: scoreboard bench for instr_aligner.
// Expected instructions come from walking the halfword stream.
module tb_instr_aligner;

  logic        clk_i;
  logic        rst_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_is_c_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        isc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] wq[$];
  int          ncmp;
  int          nerr;

  instr_aligner #(
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o),
    .fetch_data_i (fetch_data_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_is_c_o (instr_is_c_o),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, need $finish");
    $fatal(1);
  end

  task automatic build_exp(input logic [31:0] spc);
    logic [15:0] hw[$];
    logic [31:0] pc;
    int          idx;
    exp_t        e;
`ifdef ALIGNER_COMPRESSED_EN
    foreach (wq[i]) begin
      hw.push_back(wq[i][15:0]);
      hw.push_back(wq[i][31:16]);
    end
    idx = spc[1] ? 1 : 0;
    pc  = spc;
    while (idx < hw.size()) begin
      if (hw[idx][1:0] != 2'b11) begin
        e.instr = {16'h0, hw[idx]};
        e.pc    = pc;
        e.isc   = 1'b1;
        sb.push_back(e);
        idx = idx + 1;
        pc  = pc + 32'd2;
      end else if (idx + 1 < hw.size()) begin
        e.instr = {hw[idx+1], hw[idx]};
        e.pc    = pc;
        e.isc   = 1'b0;
        sb.push_back(e);
        idx = idx + 2;
        pc  = pc + 32'd4;
      end else begin
        break;
      end
    end
`else
    idx = 0;
    pc  = {spc[31:2], 2'b00};
    foreach (wq[i]) begin
      e.instr = wq[i];
      e.pc    = pc;
      e.isc   = 1'b0;
      sb.push_back(e);
      pc = pc + 32'd4;
    end
`endif
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush_i       = 1'b1;
    flush_pc_i    = pc;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
      nerr++;
      $display("FAIL flush_kill valid %b ready %b, need 0 0",
               instr_valid_o, fetch_ready_o);
    end
    @(posedge clk_i); #1;
    flush_i       = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic run_stream(input logic [31:0] spc, input int vpct,
                            input int rpct, input string nm);
    exp_t        e;
    int          wi;
    int          cyc;
    bit          held;
    bit          stl;
    logic [31:0] li;
    logic [31:0] lp;
    sb.delete();
    do_flush(spc);
    build_exp(spc);
    wi   = 0;
    cyc  = 0;
    held = 1'b0;
    stl  = 1'b0;
    li   = '0;
    lp   = '0;
    while ((wi < wq.size() || sb.size() != 0) && cyc < 600) begin
      if (!held) begin
        fetch_valid_i = (wi < wq.size()) && ($urandom_range(99) < vpct);
        fetch_data_i  = fetch_valid_i ? wq[wi] : $urandom;
      end
      instr_ready_i = $urandom_range(99) < rpct;
      @(negedge clk_i);
      if (stl) begin
        ncmp++;
        if (instr_valid_o !== 1'b1 || instr_o !== li || instr_pc_o !== lp) begin
          nerr++;
          $display("FAIL %s hold: v %b i %h pc %h, need 1 %h %h",
                   nm, instr_valid_o, instr_o, instr_pc_o, li, lp);
        end
      end
      if (instr_valid_o && instr_ready_i) begin
        if (sb.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL %s extra: instr %h pc %h, need none",
                   nm, instr_o, instr_pc_o);
        end else begin
          e = sb.pop_front();
          ncmp++;
          if (instr_o !== e.instr) begin
            nerr++;
            $display("FAIL %s instr got %h need %h", nm, instr_o, e.instr);
          end
          ncmp++;
          if (instr_pc_o !== e.pc) begin
            nerr++;
            $display("FAIL %s pc got %h need %h", nm, instr_pc_o, e.pc);
          end
          ncmp++;
          if (instr_is_c_o !== e.isc) begin
            nerr++;
            $display("FAIL %s is_c got %b need %b", nm, instr_is_c_o, e.isc);
          end
        end
      end
      held = fetch_valid_i && !fetch_ready_o;
      if (fetch_valid_i && fetch_ready_o) wi++;
      stl = instr_valid_o && !instr_ready_i;
      li  = instr_o;
      lp  = instr_pc_o;
      @(posedge clk_i); #1;
      cyc++;
    end
    ncmp++;
    if (cyc >= 600) begin
      nerr++;
      $display("FAIL %s timeout: %0d left, %0d words unused, need 0",
               nm, sb.size(), wq.size() - wi);
    end
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    flush_pc_i    = 32'h0;
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0051_0513;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
      nerr++;
      $display("FAIL rst_hs v %b r %b, need 0 0", instr_valid_o, fetch_ready_o);
    end
    ncmp++;
    if (instr_o !== 32'h0 || instr_is_c_o !== 1'b0) begin
      nerr++;
      $display("FAIL rst_out i %h c %b, need 0 0", instr_o, instr_is_c_o);
    end
    @(posedge clk_i); #1;
    rst_i         = 1'b0;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL rst_valid got %b need 0", instr_valid_o);
    end
    ncmp++;
    if (instr_pc_o !== 32'h100) begin
      nerr++;
      $display("FAIL rst_pc got %h need 00000100", instr_pc_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_rv32();
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0051_0513;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0051_0513) begin
      nerr++;
      $display("FAIL rv32_instr v %b i %h, need 1 00510513",
               instr_valid_o, instr_o);
    end
    ncmp++;
    if (instr_pc_o !== 32'h100 || instr_is_c_o !== 1'b0) begin
      nerr++;
      $display("FAIL rv32_pc pc %h c %b, need 00000100 0",
               instr_pc_o, instr_is_c_o);
    end
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    ncmp++;
    if (instr_pc_o !== 32'h104) begin
      nerr++;
      $display("FAIL rv32_next got %h need 00000104", instr_pc_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_pair();
    do_flush(32'h100);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h4501_0505;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
`ifdef ALIGNER_COMPRESSED_EN
    ncmp++;
    if (instr_o !== 32'h0505 || instr_pc_o !== 32'h100) begin
      nerr++;
      $display("FAIL pair_c0 i %h pc %h, need 00000505 00000100",
               instr_o, instr_pc_o);
    end
    ncmp++;
    if (fetch_ready_o !== 1'b1 || instr_is_c_o !== 1'b1) begin
      nerr++;
      $display("FAIL pair_c0_rdy r %b c %b, need 1 1",
               fetch_ready_o, instr_is_c_o);
    end
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    ncmp++;
    if (instr_o !== 32'h4501 || instr_pc_o !== 32'h102) begin
      nerr++;
      $display("FAIL pair_c1 i %h pc %h, need 00004501 00000102",
               instr_o, instr_pc_o);
    end
    ncmp++;
    if (fetch_ready_o !== 1'b0 || instr_valid_o !== 1'b1) begin
      nerr++;
      $display("FAIL pair_c1_rdy r %b v %b, need 0 1",
               fetch_ready_o, instr_valid_o);
    end
`else
    ncmp++;
    if (instr_o !== 32'h4501_0505 || instr_pc_o !== 32'h100) begin
      nerr++;
      $display("FAIL pair_w i %h pc %h, need 45010505 00000100",
               instr_o, instr_pc_o);
    end
    ncmp++;
    if (fetch_ready_o !== 1'b1 || instr_is_c_o !== 1'b0) begin
      nerr++;
      $display("FAIL pair_w_rdy r %b c %b, need 1 0",
               fetch_ready_o, instr_is_c_o);
    end
`endif
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    ncmp++;
    if (instr_pc_o !== 32'h104) begin
      nerr++;
      $display("FAIL pair_next got %h need 00000104", instr_pc_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_straddle_stall();
`ifdef ALIGNER_COMPRESSED_EN
    do_flush(32'h100);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0513_0505;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ncmp++;
    if (instr_o !== 32'h0505 || instr_pc_o !== 32'h100) begin
      nerr++;
      $display("FAIL strad_c i %h pc %h, need 00000505 00000100",
               instr_o, instr_pc_o);
    end
    @(posedge clk_i); #1;
    fetch_data_i  = 32'h1234_0051;
    instr_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      ncmp++;
      if (instr_o !== 32'h0051_0513 || instr_pc_o !== 32'h102 ||
          instr_valid_o !== 1'b1 || fetch_ready_o !== 1'b0 ||
          instr_is_c_o !== 1'b0) begin
        nerr++;
        $display("FAIL stall%0d i %h pc %h v %b r %b c %b, need 00510513 00000102 1 0 0",
                 k, instr_o, instr_pc_o, instr_valid_o, fetch_ready_o,
                 instr_is_c_o);
      end
      @(posedge clk_i); #1;
    end
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ncmp++;
    if (fetch_ready_o !== 1'b1 || instr_o !== 32'h0051_0513) begin
      nerr++;
      $display("FAIL stall_rel r %b i %h, need 1 00510513",
               fetch_ready_o, instr_o);
    end
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h1234 ||
        instr_pc_o !== 32'h106 || fetch_ready_o !== 1'b0) begin
      nerr++;
      $display("FAIL strad_pend v %b i %h pc %h r %b, need 1 00001234 00000106 0",
               instr_valid_o, instr_o, instr_pc_o, fetch_ready_o);
    end
    @(posedge clk_i); #1;
`else
    wq = '{32'h0513_0505, 32'h1234_0051};
    run_stream(32'h100, 100, 25, "strad");
`endif
  endtask

  task automatic test_flush_half();
`ifdef ALIGNER_COMPRESSED_EN
    do_flush(32'h202);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0001_AAAA;
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b1) begin
      nerr++;
      $display("FAIL bubble v %b r %b, need 0 1", instr_valid_o, fetch_ready_o);
    end
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0001 ||
        instr_pc_o !== 32'h202) begin
      nerr++;
      $display("FAIL half_tgt v %b i %h pc %h, need 1 00000001 00000202",
               instr_valid_o, instr_o, instr_pc_o);
    end
    @(posedge clk_i); #1;
    instr_ready_i = 1'b0;
`else
    wq = '{32'h0001_AAAA};
    run_stream(32'h202, 100, 100, "half");
`endif
  endtask

  task automatic test_flush_hs();
    do_flush(32'h100);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0051_0513;
    instr_ready_i = 1'b1;
    flush_i       = 1'b1;
    flush_pc_i    = 32'h300;
    @(negedge clk_i);
    ncmp++;
    if (fetch_ready_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL fhs_kill r %b v %b, need 0 0", fetch_ready_o, instr_valid_o);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    ncmp++;
    if (instr_pc_o !== 32'h300 || instr_o !== 32'h0051_0513 ||
        instr_valid_o !== 1'b1) begin
      nerr++;
      $display("FAIL fhs_pc pc %h i %h v %b, need 00000300 00510513 1",
               instr_pc_o, instr_o, instr_valid_o);
    end
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_flush(32'h100);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0513_0505;
    instr_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i        = 1'b1;
    fetch_data_i = 32'h1234_0051;
    @(negedge clk_i);
    ncmp++;
    if (instr_valid_o !== 1'b0 || fetch_ready_o !== 1'b0 ||
        instr_o !== 32'h0 || instr_is_c_o !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_kill v %b r %b i %h c %b, need 0 0 0 0",
               instr_valid_o, fetch_ready_o, instr_o, instr_is_c_o);
    end
    @(posedge clk_i); #1;
    rst_i        = 1'b0;
    fetch_data_i = 32'h0051_0513;
    @(negedge clk_i);
    ncmp++;
    if (instr_o !== 32'h0051_0513 || instr_pc_o !== 32'h100 ||
        instr_valid_o !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_after i %h pc %h v %b, need 00510513 00000100 1",
               instr_o, instr_pc_o, instr_valid_o);
    end
    @(posedge clk_i); #1;
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    wq = '{32'h0001_0001, 32'h0051_0513, 32'h0513_0001, 32'h0001_0051};
    run_stream(32'hFFFF_FFFC, 100, 100, "wrap");
  endtask

  task automatic test_back_to_back();
    wq.delete();
    for (int i = 0; i < 40; i++) wq.push_back($urandom);
    run_stream(32'h400, 100, 100, "b2b");
  endtask

  task automatic test_random();
    logic [31:0] starts[3];
    starts = '{32'h800, 32'h802, 32'h7FE};
    for (int r = 0; r < 3; r++) begin
      wq.delete();
      for (int i = 0; i < 40; i++) wq.push_back($urandom);
      run_stream(starts[r], 40 + 20 * r, 70 - 20 * r, "rand");
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    test_reset();
    test_rv32();
    test_pair();
    test_straddle_stall();
    test_flush_half();
    test_flush_hs();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
